// File: rtl/clk_div_gen.sv
// Multi-channel divided-clock / tick generator; config updates land at period wraps (CLK_DIV_GEN_PHASE_EN adds cfg_phase).
// Latency: stopped channel accepted at edge k runs from edge k+1; running channel applies at its next wrap.
// Backpressure: cfg_ready drops for a channel while its shadow update is pending; out-of-range channels always accept.
module clk_div_gen #(
  parameter int CHANNELS = 2,
  parameter int DIV_W    = 8,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic                cfg_en,
`ifdef CLK_DIV_GEN_PHASE_EN
  input  logic [DIV_W-1:0]    cfg_phase,
`endif
  output logic [CHANNELS-1:0] div_out,
  output logic [CHANNELS-1:0] div_tick,
  output logic [CHANNELS-1:0] active
);

  localparam logic [DIV_W-1:0] ONE    = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO    = DIV_W'(2);
  localparam logic [CH_W:0]    CH_LIM = (CH_W + 1)'(CHANNELS);

  logic                chan_ok;
  logic [DIV_W-1:0]    div_s;
  logic [CHANNELS-1:0] pend_vec;

  assign chan_ok = ({1'b0, cfg_chan} < CH_LIM);
  assign div_s   = (cfg_div < TWO) ? TWO : cfg_div;

  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (chan_ok && (cfg_chan == CH_W'(i))) begin
        cfg_ready = ~pend_vec[i];
      end
    end
  end

`ifdef CLK_DIV_GEN_PHASE_EN
  logic [DIV_W-1:0] phase_s;
  assign phase_s = (cfg_phase >= div_s) ? '0 : cfg_phase;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] d;
    logic [DIV_W-1:0] sh_div;
    logic [DIV_W-1:0] cnt_nxt;
    logic [DIV_W-1:0] load_cnt;
    logic             en;
    logic             sh_en;
    logic             pend;
    logic             wrap;
    logic             acc;
    logic             apply;
    logic             out_q;
    logic             tick_q;
    logic             act_q;

    assign acc     = cfg_valid & cfg_ready & chan_ok & (cfg_chan == CH_W'(g));
    assign wrap    = (cnt == (d - ONE));
    // a stopped channel has no period to finish, so it takes the update immediately
    assign apply   = pend & (~en | wrap);
    assign cnt_nxt = wrap ? '0 : (cnt + ONE);

`ifdef CLK_DIV_GEN_PHASE_EN
    logic [DIV_W-1:0] sh_phase;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sh_phase <= '0;
      end else if (acc) begin
        sh_phase <= phase_s;
      end
    end

    assign load_cnt = sh_phase;
`else
    assign load_cnt = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt    <= '0;
        d      <= TWO;
        en     <= 1'b0;
        sh_div <= TWO;
        sh_en  <= 1'b0;
        pend   <= 1'b0;
        out_q  <= 1'b0;
        tick_q <= 1'b0;
        act_q  <= 1'b0;
      end else begin
        if (acc) begin
          sh_div <= div_s;
          sh_en  <= cfg_en;
          pend   <= 1'b1;
        end
        if (apply) begin
          pend  <= 1'b0;
          d     <= sh_div;
          en    <= sh_en;
          act_q <= sh_en;
          if (sh_en) begin
            cnt    <= load_cnt;
            out_q  <= (load_cnt < (sh_div >> 1));
            tick_q <= (load_cnt == '0);
          end else begin
            cnt    <= '0;
            out_q  <= 1'b0;
            tick_q <= 1'b0;
          end
        end else if (en) begin
          cnt    <= cnt_nxt;
          out_q  <= (cnt_nxt < (d >> 1));
          tick_q <= (cnt_nxt == '0);
        end else begin
          cnt    <= '0;
          out_q  <= 1'b0;
          tick_q <= 1'b0;
        end
      end
    end

    assign pend_vec[g] = pend;
    assign div_out[g]  = out_q;
    assign div_tick[g] = tick_q;
    assign active[g]   = act_q;
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen: reset, divisor patterns, retune/disable at wrap, out-of-range writes, optional phase.
module tb_clk_div_gen;
  localparam int CH = 3;
  localparam int DW = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [CW-1:0] cfg_chan = '0;
  logic [DW-1:0] cfg_div = '0;
  logic          cfg_en = 1'b0;
`ifdef CLK_DIV_GEN_PHASE_EN
  logic [DW-1:0] cfg_phase = '0;
`endif
  logic [CH-1:0] div_out;
  logic [CH-1:0] div_tick;
  logic [CH-1:0] active;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  clk_div_gen #(.CHANNELS(CH), .DIV_W(DW), .CH_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_div   (cfg_div),
    .cfg_en    (cfg_en),
`ifdef CLK_DIV_GEN_PHASE_EN
    .cfg_phase (cfg_phase),
`endif
    .div_out   (div_out),
    .div_tick  (div_tick),
    .active    (active)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int ch, input int dv, input bit en);
    cfg_chan  = CW'(ch);
    cfg_div   = DW'(dv);
    cfg_en    = en;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

`ifdef CLK_DIV_GEN_PHASE_EN
  task automatic send_ph(input int ch, input int dv, input bit en, input int ph);
    cfg_phase = DW'(ph);
    send(ch, dv, en);
  endtask
`endif

  task automatic do_reset();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    step();
  endtask

  initial begin
    // reset state
    step();
    step();
    chk("rst_div_out", div_out, 0);
    chk("rst_div_tick", div_tick, 0);
    chk("rst_active", active, 0);
    for (int c = 0; c < CH; c++) begin
      cfg_chan = CW'(c);
      #1;
      chk("rst_cfg_ready", cfg_ready, 1);
    end
    rst = 1'b0;
    step();

    // ch0 D=4 from stopped
    cfg_chan = 0;
    #1;
    chk("d4_ready_pre", cfg_ready, 1);
    send(0, 4, 1'b1);
    chk("d4_k_out", div_out[0], 0);
    chk("d4_k_ready", cfg_ready, 0);
    chk("d4_k_active", active[0], 0);
    step();
    chk("d4_k1_ready", cfg_ready, 1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      chk("d4_out", div_out[0], ((i % 4) < 2) ? 1 : 0);
      chk("d4_tick", div_tick[0], ((i % 4) == 0) ? 1 : 0);
      chk("d4_active", active[0], 1);
    end

    // async reset mid-cycle with ch1 pending
    send(1, 5, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk("arst_div_out", div_out, 0);
    chk("arst_div_tick", div_tick, 0);
    chk("arst_active", active, 0);
    cfg_chan = 1;
    #1;
    chk("arst_ready_ch1", cfg_ready, 1);
    step();
    rst = 1'b0;
    step();
    step();
    chk("arst_pend_lost_out", div_out, 0);
    chk("arst_pend_lost_act", active, 0);

    // ch1 odd divisor D=5
    send(1, 5, 1'b1);
    step();
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      chk("d5_out", div_out[1], ((i % 5) < 2) ? 1 : 0);
      chk("d5_tick", div_tick[1], ((i % 5) == 0) ? 1 : 0);
      chk("d5_ch0_idle", div_out[0], 0);
    end
    chk("d5_active", active, 3'b010);

    // D=0 on ch0 and D=1 on ch1 both give period 2
    do_reset();
    send(0, 0, 1'b1);
    send(1, 1, 1'b1);
    chk("d01_b_out", div_out[1:0], 2'b01);
    step();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      chk("d01_out", div_out[1:0], (i % 2 == 0) ? 2'b10 : 2'b01);
      chk("d01_tick", div_tick[1:0], (i % 2 == 0) ? 2'b10 : 2'b01);
    end

    // retune ch0 4 -> 6 mid-period
    do_reset();
    send(0, 4, 1'b1);
    step();
    step();
    chk("rt_cnt1_out", div_out[0], 1);
    send(0, 6, 1'b1);
    chk("rt_cnt2_out", div_out[0], 0);
    chk("rt_cnt2_ready", cfg_ready, 0);
    cfg_chan = 1;
    #1;
    chk("rt_ch1_ready", cfg_ready, 1);
    cfg_chan = 0;
    step();
    chk("rt_cnt3_out", div_out[0], 0);
    chk("rt_cnt3_tick", div_tick[0], 0);
    chk("rt_cnt3_ready", cfg_ready, 0);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("rt_d6_out", div_out[0], ((i % 6) < 3) ? 1 : 0);
      chk("rt_d6_tick", div_tick[0], ((i % 6) == 0) ? 1 : 0);
      if (i == 0) chk("rt_ready_after", cfg_ready, 1);
    end

    // disable ch0 while running: takes effect at wrap
    send(0, 6, 1'b0);
    chk("dis_k_out", div_out[0], 1);
    chk("dis_k_active", active[0], 1);
    for (int j = 1; j < 6; j++) begin
      step();
      chk("dis_run_out", div_out[0], (j < 3) ? 1 : 0);
      chk("dis_run_active", active[0], 1);
    end
    step();
    chk("dis_wrap_out", div_out[0], 0);
    chk("dis_wrap_tick", div_tick[0], 0);
    chk("dis_wrap_active", active[0], 0);
    chk("dis_wrap_ready", cfg_ready, 1);
    for (int j = 0; j < 3; j++) begin
      step();
      chk("dis_idle_out", div_out[0], 0);
    end

    // out-of-range channel write
    cfg_chan = 3;
    #1;
    chk("oor_ready", cfg_ready, 1);
    send(3, 4, 1'b1);
    for (int c = 0; c < CH; c++) begin
      cfg_chan = CW'(c);
      #1;
      chk("oor_no_pending", cfg_ready, 1);
    end
    step();
    step();
    chk("oor_div_out", div_out, 0);
    chk("oor_active", active, 0);

`ifdef CLK_DIV_GEN_PHASE_EN
    // ch0 phase 0, ch1 phase 2, both D=8; ch1 starts one cycle after ch0
    do_reset();
    send_ph(0, 8, 1'b1, 0);
    send_ph(1, 8, 1'b1, 2);
    chk("ph_b_out0", div_out[0], 1);
    chk("ph_b_tick0", div_tick[0], 1);
    step();
    chk("ph_c_tick1", div_tick[1], 0);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) step();
      chk("ph_out0", div_out[0], (((i + 1) % 8) < 4) ? 1 : 0);
      chk("ph_out1", div_out[1], (((i + 2) % 8) < 4) ? 1 : 0);
      chk("ph_tick1", div_tick[1], (((i + 2) % 8) == 0) ? 1 : 0);
    end

    // phase >= D behaves as 0
    do_reset();
    send_ph(0, 8, 1'b1, 9);
    step();
    chk("ph9_out", div_out[0], 1);
    chk("ph9_tick", div_tick[0], 1);
    for (int i = 1; i < 8; i++) begin
      step();
      chk("ph9_run", div_out[0], (i < 4) ? 1 : 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
